// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel run-time programmable clock divider; optional sync port under CLK_DIV_PROG_SYNC_EN
module clk_div_prog #(
    parameter int  CH          = 4,
    parameter int  W           = 16,
    parameter int  DEFAULT_DIV = 50,
    localparam int CW          = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_div,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic          sync,
`endif
    output logic [CH-1:0] clk_div,
    output logic [CH-1:0] tick
);

    logic [W-1:0]  div     [CH];
    logic [W-1:0]  cnt     [CH];
    logic [W-1:0]  cnt_nxt [CH];
    logic [CH-1:0] wrap;
    logic [CH-1:0] apply;

    logic          pend_valid;
    logic [CW-1:0] pend_ch;
    logic [W-1:0]  pend_div;

    logic          sync_i;
    logic          ch_ok;
    logic [W-1:0]  div_clamped;

`ifdef CLK_DIV_PROG_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // A single pending slot: the port is busy exactly while an update waits
    assign cfg_ready   = !pend_valid;
    assign ch_ok       = (32'(cfg_ch) < 32'(CH));
    // Divisors below 2 cannot form a waveform, so they are stored as 2
    assign div_clamped = (cfg_div < W'(2)) ? W'(2) : cfg_div;

    // Per-channel period boundary, next count and pending-update apply decision
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            wrap[i]    = (cnt[i] == div[i] - W'(1));
            cnt_nxt[i] = wrap[i] ? '0 : cnt[i] + W'(1);
            // Enabled channels switch only at a period boundary (or on a realign),
            // so the old period always completes and no runt pulse appears
            apply[i]   = pend_valid && (pend_ch == CW'(i)) && (!en[i] || wrap[i] || sync_i);
        end
    end

    // Channel counters, divisors and registered waveform/tick outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
                div[i] <= W'(DEFAULT_DIV);
            end
            clk_div <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!en[i] || sync_i) begin
                    cnt[i]     <= '0;
                    clk_div[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else begin
                    cnt[i]     <= cnt_nxt[i];
                    // Low for floor(div/2) counts, high for the rest of the period
                    clk_div[i] <= (cnt_nxt[i] >= (div[i] >> 1));
                    tick[i]    <= wrap[i];
                end
                if (apply[i]) begin
                    div[i] <= pend_div;
                end
            end
        end
    end

    // Pending slot: capture on handshake, drop out-of-range channels, clear on apply
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= W'(2);
        end else if (cfg_valid && cfg_ready) begin
            if (ch_ok) begin
                pend_valid <= 1'b1;
                pend_ch    <= cfg_ch;
                pend_div   <= div_clamped;
            end
        end else if (|apply) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard bench for clk_div_prog with directed and random stimulus
module tb_clk_div_prog;
    localparam int CH = 3;
    localparam int W  = 16;
    localparam int DD = 50;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] en = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch = '0;
    logic [W-1:0]  cfg_div = '0;
    logic [CH-1:0] clk_div;
    logic [CH-1:0] tick;
`ifdef CLK_DIV_PROG_SYNC_EN
    logic          sync = 1'b0;
`endif

    always #5 clk = ~clk;

    clk_div_prog #(.CH(CH), .W(W), .DEFAULT_DIV(DD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef CLK_DIV_PROG_SYNC_EN
        .sync      (sync),
`endif
        .clk_div   (clk_div),
        .tick      (tick)
    );

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    typedef logic [2*CH:0] obs_t;
    obs_t exp_q[$];

    // Reference model: phase within the current period, period length, pending updates
    int            m_ph [CH];
    int            m_d  [CH];
    logic [CH-1:0] m_lvl;
    logic [CH-1:0] m_tk;
    int            p_ch[$];
    int            p_div[$];
    bit            last_acc;

    task automatic model_step(input logic s);
        bit ready;
        bit last;
        bit upd;
        bit done;
        last_acc = 1'b0;
        done     = 1'b0;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_ph[i] = 0;
                m_d[i]  = DD;
            end
            m_lvl = '0;
            m_tk  = '0;
            p_ch.delete();
            p_div.delete();
        end else begin
            ready = (p_ch.size() == 0);
            for (int i = 0; i < CH; i++) begin
                last = en[i] && (m_ph[i] == m_d[i] - 1);
                upd  = !ready && (p_ch[0] == i) && (!en[i] || last || s);
                if (!en[i] || s) begin
                    m_ph[i]  = 0;
                    m_lvl[i] = 1'b0;
                    m_tk[i]  = 1'b0;
                end else begin
                    m_tk[i]  = last;
                    m_ph[i]  = (m_ph[i] + 1) % m_d[i];
                    m_lvl[i] = (m_ph[i] >= m_d[i] / 2);
                end
                if (upd) begin
                    m_d[i] = p_div[0];
                    done   = 1'b1;
                end
            end
            if (done) begin
                void'(p_ch.pop_front());
                void'(p_div.pop_front());
            end
            if (ready && cfg_valid) begin
                last_acc = 1'b1;
                if (int'(cfg_ch) < CH) begin
                    p_ch.push_back(int'(cfg_ch));
                    p_div.push_back((cfg_div < 2) ? 2 : int'(cfg_div));
                end
            end
        end
        exp_q.push_back({(p_ch.size() == 0), m_lvl, m_tk});
    endtask

    // One clock: predict the result of the coming edge, then sample 1 time unit after it
    task automatic cyc();
        logic s;
        s = 1'b0;
`ifdef CLK_DIV_PROG_SYNC_EN
        s = sync;
`endif
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    // Monitor: every edge presents a new output word, compared against the queued prediction
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow at cycle %0d", cyc_no);
            end else begin
                e = exp_q.pop_front();
                a = {cfg_ready, clk_div, tick};
                if (a !== e) begin
                    bad++;
                    $display("FAIL sb cycle %0d: got ready=%b clk_div=%b tick=%b, need ready=%b clk_div=%b tick=%b",
                             cyc_no, a[2*CH], a[2*CH-1:CH], a[CH-1:0], e[2*CH], e[2*CH-1:CH], e[CH-1:0]);
                end
            end
        end
    end

    initial begin
        int first_hi;
        int first_tk;
        int second_tk;
        int low;
        int n;
        int tk_at;
        int nt;
        int nh;
        int k;
        logic prev_rdy;

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_clk_div", int'(clk_div), 0);
        chk("rst_tick", int'(tick), 0);

        // Channel 0 at the default divisor
        en = 3'b001;
        first_hi = -1; first_tk = -1; second_tk = -1;
        for (int i = 1; i <= 110; i++) begin
            cyc();
            if (first_hi < 0 && clk_div[0]) first_hi = i;
            if (tick[0]) begin
                if (first_tk < 0) first_tk = i;
                else if (second_tk < 0) second_tk = i;
            end
        end
        chk("ch0_first_rise", first_hi, DD / 2);
        chk("ch0_first_tick", first_tk, DD);
        chk("ch0_period", second_tk - first_tk, DD);

        // Divisor 3 into disabled channel 1
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3;
        cyc();
        cfg_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 20 && !cfg_ready; i++) begin
            low++;
            cyc();
        end
        chk("ch1_ready_low", low, 1);
        en = 3'b011;
        first_hi = -1; first_tk = -1; nt = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (first_hi < 0 && clk_div[1]) first_hi = i;
            if (tick[1]) begin
                nt++;
                if (first_tk < 0) first_tk = i;
            end
        end
        chk("ch1_first_rise", first_hi, 1);
        chk("ch1_first_tick", first_tk, 3);
        chk("ch1_ticks_12", nt, 4);

        // Divisor 10 into running channel 0 at cnt=5: old period completes first
        en[0] = 1'b0;
        cyc();
        en[0] = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd10;
        cyc();
        cfg_valid = 1'b0;
        n = 6; tk_at = -1; prev_rdy = cfg_ready;
        while (n < 100 && tk_at < 0) begin
            cyc();
            n++;
            if (tick[0]) tk_at = n;
            else prev_rdy = cfg_ready;
        end
        chk("upd_old_period_end", tk_at, DD);
        chk("upd_ready_before_apply", int'(prev_rdy), 0);
        chk("upd_ready_after_apply", int'(cfg_ready), 1);
        first_hi = -1; first_tk = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (first_hi < 0 && clk_div[0]) first_hi = i;
            if (first_tk < 0 && tick[0]) first_tk = i;
        end
        chk("upd_new_rise", first_hi, 5);
        chk("upd_new_tick", first_tk, 10);

        // Clamp of 0 and 1 on channel 2, then an out-of-range channel
        for (int v = 0; v < 2; v++) begin
            en[2] = 1'b0;
            cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'(v);
            cyc();
            cfg_valid = 1'b0;
            cyc();
            en[2] = 1'b1;
            nt = 0; nh = 0;
            for (int i = 0; i < 8; i++) begin
                cyc();
                if (tick[2]) nt++;
                if (clk_div[2]) nh++;
            end
            chk($sformatf("clamp%0d_ticks", v), nt, 4);
            chk($sformatf("clamp%0d_highs", v), nh, 4);
        end
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd9;
        cyc();
        cfg_valid = 1'b0;
        chk("drop_ready", int'(cfg_ready), 1);
        cyc();

        // Held offer behind a pending update, then reset mid-wait
        en[0] = 1'b0;
        cyc();
        en[0] = 1'b1;
        cyc();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd30;
        cyc();
        cfg_ch = 2'd2; cfg_div = 16'd7;
        for (int i = 0; i < 3; i++) cyc();
        chk("hold_ready", int'(cfg_ready), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0; cfg_valid = 1'b0; en = '0;
        chk("midrst_ready", int'(cfg_ready), 1);
        chk("midrst_clk_div", int'(clk_div), 0);
        chk("midrst_tick", int'(tick), 0);
        en = 3'b001;
        first_tk = -1;
        for (int i = 1; i <= 60 && first_tk < 0; i++) begin
            cyc();
            if (tick[0]) first_tk = i;
        end
        chk("midrst_default_div", first_tk, DD);

`ifdef CLK_DIV_PROG_SYNC_EN
        // Realign D=4 and D=6 channels that run out of phase
        en = '0;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
        cyc();
        cfg_valid = 1'b0;
        cyc();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd6;
        cyc();
        cfg_valid = 1'b0;
        cyc();
        en = 3'b001;
        cyc();
        en = 3'b011;
        for (int i = 0; i < 5; i++) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("sync_clk_div", int'(clk_div[1:0]), 0);
        chk("sync_tick", int'(tick[1:0]), 0);
        first_tk = -1; second_tk = -1;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            if (tick[0] && tick[1]) begin
                if (first_tk < 0) first_tk = i;
                else if (second_tk < 0) second_tk = i;
            end
        end
        chk("sync_first_joint_tick", first_tk, 12);
        chk("sync_joint_period", second_tk - first_tk, 12);
`endif

        // Randomized traffic checked by the scoreboard only
        en = '0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) begin
                k = $urandom_range(0, CH - 1);
                en[k] = ~en[k];
            end
            if (!cfg_valid && $urandom_range(0, 5) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = CW'($urandom_range(0, 3));
                cfg_div   = W'($urandom_range(0, 12));
            end
`ifdef CLK_DIV_PROG_SYNC_EN
            sync = ($urandom_range(0, 39) == 0);
`endif
            cyc();
            if (last_acc) cfg_valid = 1'b0;
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
`ifdef CLK_DIV_PROG_SYNC_EN
        sync = 1'b0;
`endif
        cyc();
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
